// File: rtl/me_scan_ctrl.sv
// Full-search scan sequencer for the motion-estimation datapath: loads the current
// macroblock, sweeps every candidate column strip, and tags each SAD with its position.
module me_scan_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_LAT    = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          cur_rd_en,
    output logic [$clog2(MACRO_DIM)-1:0]                  cur_rd_addr,
    output logic                                          spr_rd_en,
    output logic [$clog2(SEARCH_DIM)-1:0]                 spr_rd_row,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]     spr_rd_col,
    output logic                                          en_cpr,
    output logic                                          en_spr,
    output logic                                          valid,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]     cand_x,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]     cand_y
);

    localparam int NX    = SEARCH_DIM - MACRO_DIM + 1;
    localparam int AW    = $clog2(MACRO_DIM);
    localparam int RW    = $clog2(SEARCH_DIM);
    localparam int CW    = $clog2(NX);
    localparam int DW    = $clog2(SAD_LAT + 1) + 1;
    localparam int DEPTH = 1 + SAD_LAT;

    localparam logic [AW-1:0] ADDR_LAST  = AW'(MACRO_DIM - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SEARCH_DIM - 1);
    localparam logic [RW-1:0] ROW_FILL   = RW'(MACRO_DIM - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(NX - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(SAD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_CUR,
        SEARCH,
        DRAIN
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_curRdEn;
    logic [AW-1:0]   r_curAddr;
    logic            r_sprRdEn;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic [DW-1:0]   r_drainCnt;
    logic            r_enCpr;
    logic            r_enSpr;

    logic            r_pipeValid [DEPTH];
    logic [CW-1:0]   r_pipeX     [DEPTH];
    logic [CW-1:0]   r_pipeY     [DEPTH];

    logic            w_candEvent;
    logic [RW-1:0]   w_rowOff;
    logic [CW-1:0]   w_candY;

    // A candidate is complete once the strip has accumulated MACRO_DIM rows.
    assign w_candEvent = r_sprRdEn && (r_row >= ROW_FILL);
    assign w_rowOff    = r_row - ROW_FILL;
    assign w_candY     = w_rowOff[CW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_curRdEn  <= 1'b0;
            r_curAddr  <= '0;
            r_sprRdEn  <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_drainCnt <= '0;
            r_enCpr    <= 1'b0;
            r_enSpr    <= 1'b0;
        end else begin
            r_enCpr <= r_curRdEn;
            r_enSpr <= r_sprRdEn;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    // The done cycle is still IDLE; a start landing on it is dropped.
                    if (start && !r_done) begin
                        r_state   <= LOAD_CUR;
                        r_busy    <= 1'b1;
                        r_curRdEn <= 1'b1;
                        r_curAddr <= '0;
                    end
                end
                LOAD_CUR: begin
                    if (r_curAddr == ADDR_LAST) begin
                        r_state   <= SEARCH;
                        r_curRdEn <= 1'b0;
                        r_sprRdEn <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                    end else begin
                        r_curAddr <= r_curAddr + 1'b1;
                    end
                end
                SEARCH: begin
                    if (r_row == ROW_LAST) begin
                        if (r_col == COL_LAST) begin
                            r_state    <= DRAIN;
                            r_sprRdEn  <= 1'b0;
                            r_drainCnt <= '0;
                        end else begin
                            r_col <= r_col + 1'b1;
                            r_row <= '0;
                        end
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Each stage only captures a position alongside a valid, so the tail holds the last tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipeValid[i] <= 1'b0;
                r_pipeX[i]     <= '0;
                r_pipeY[i]     <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_candEvent;
            if (w_candEvent) begin
                r_pipeX[0] <= r_col;
                r_pipeY[0] <= w_candY;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                if (r_pipeValid[i-1]) begin
                    r_pipeX[i] <= r_pipeX[i-1];
                    r_pipeY[i] <= r_pipeY[i-1];
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign cur_rd_en   = r_curRdEn;
    assign cur_rd_addr = r_curAddr;
    assign spr_rd_en   = r_sprRdEn;
    assign spr_rd_row  = r_row;
    assign spr_rd_col  = r_col;
    assign en_cpr      = r_enCpr;
    assign en_spr      = r_enSpr;
    assign valid       = r_pipeValid[DEPTH-1];
    assign cand_x      = r_pipeX[DEPTH-1];
    assign cand_y      = r_pipeY[DEPTH-1];

endmodule

// File: tb/tb_me_scan_ctrl.sv
// Random start/reset stimulus on a default and a small-parameter me_scan_ctrl, each checked
// every cycle against a position-in-search arithmetic model of the scan schedule.
module tb_me_scan_ctrl;

    localparam int M0 = 16, S0 = 48, L0 = 2;
    localparam int M1 = 4,  S1 = 8,  L1 = 1;
    localparam int NX0 = S0 - M0 + 1;
    localparam int NX1 = S1 - M1 + 1;
    localparam int TOTAL0 = M0 + NX0 * S0 + L0 + 1;
    localparam int TOTAL1 = M1 + NX1 * S1 + L1 + 1;

    typedef struct {
        int busy, done, curEn, curAddr, sprEn, row, col, enCpr, enSpr, valid, cx, cy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic       d0_busy, d0_done, d0_curEn, d0_sprEn, d0_enCpr, d0_enSpr, d0_valid;
    logic [3:0] d0_curAddr;
    logic [5:0] d0_row, d0_col, d0_cx, d0_cy;

    logic       d1_busy, d1_done, d1_curEn, d1_sprEn, d1_enCpr, d1_enSpr, d1_valid;
    logic [1:0] d1_curAddr;
    logic [2:0] d1_row, d1_col, d1_cx, d1_cy;

    int checkCount = 0;
    int passCount  = 0;
    int t0 = 0, t1 = 0;
    int held0x = 0, held0y = 0, held1x = 0, held1y = 0;
    int validCnt0 = 0, validCnt1 = 0;

    always #5 clk = ~clk;

    me_scan_ctrl #(.MACRO_DIM(M0), .SEARCH_DIM(S0), .SAD_LAT(L0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .busy(d0_busy), .done(d0_done),
        .cur_rd_en(d0_curEn), .cur_rd_addr(d0_curAddr),
        .spr_rd_en(d0_sprEn), .spr_rd_row(d0_row), .spr_rd_col(d0_col),
        .en_cpr(d0_enCpr), .en_spr(d0_enSpr),
        .valid(d0_valid), .cand_x(d0_cx), .cand_y(d0_cy)
    );

    me_scan_ctrl #(.MACRO_DIM(M1), .SEARCH_DIM(S1), .SAD_LAT(L1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .busy(d1_busy), .done(d1_done),
        .cur_rd_en(d1_curEn), .cur_rd_addr(d1_curAddr),
        .spr_rd_en(d1_sprEn), .spr_rd_row(d1_row), .spr_rd_col(d1_col),
        .en_cpr(d1_enCpr), .en_spr(d1_enSpr),
        .valid(d1_valid), .cand_x(d1_cx), .cand_y(d1_cy)
    );

    // t is the cycle index since an accepted start (1 = first busy cycle, 0 = idle).
    function automatic exp_t expectAt(int m, int s, int l, int t);
        exp_t e;
        int nx, total, k, kv;
        e = '{default: 0};
        nx = s - m + 1;
        total = m + nx * s + l + 1;
        k  = t - m - 1;
        kv = k - 1 - l;
        e.busy    = (t >= 1 && t <= total) ? 1 : 0;
        e.done    = (t == total + 1) ? 1 : 0;
        e.curEn   = (t >= 1 && t <= m) ? 1 : 0;
        e.curAddr = t - 1;
        e.enCpr   = (t >= 2 && t <= m + 1) ? 1 : 0;
        e.sprEn   = (t >= 1 && k >= 0 && k < nx * s) ? 1 : 0;
        e.col     = (k >= 0) ? k / s : 0;
        e.row     = (k >= 0) ? k % s : 0;
        e.enSpr   = (t >= 1 && k >= 1 && k <= nx * s) ? 1 : 0;
        if (t >= 1 && kv >= 0 && kv < nx * s && (kv % s) >= m - 1) begin
            e.valid = 1;
            e.cx    = kv / s;
            e.cy    = kv % s - (m - 1);
        end
        return e;
    endfunction

    function automatic int advance(int t, logic st, int total);
        if (t == 0) return st ? 1 : 0;
        if (t == total + 1) return 0;
        return t + 1;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (time %0t)", tag, observed, expected, $time);
    endtask

    task automatic checkDut(input string nm, input exp_t e,
                            input int busy, input int done, input int curEn, input int curAddr,
                            input int sprEn, input int row, input int col, input int enCpr,
                            input int enSpr, input int vld, input int cx, input int cy);
        checkOutput({nm, ".busy"},   busy,  e.busy);
        checkOutput({nm, ".done"},   done,  e.done);
        checkOutput({nm, ".curEn"},  curEn, e.curEn);
        checkOutput({nm, ".sprEn"},  sprEn, e.sprEn);
        checkOutput({nm, ".enCpr"},  enCpr, e.enCpr);
        checkOutput({nm, ".enSpr"},  enSpr, e.enSpr);
        checkOutput({nm, ".valid"},  vld,   e.valid);
        checkOutput({nm, ".candX"},  cx,    e.cx);
        checkOutput({nm, ".candY"},  cy,    e.cy);
        if (e.curEn != 0) checkOutput({nm, ".curAddr"}, curAddr, e.curAddr);
        if (e.sprEn != 0) begin
            checkOutput({nm, ".sprRow"}, row, e.row);
            checkOutput({nm, ".sprCol"}, col, e.col);
        end
    endtask

    task automatic evaluateAll();
        exp_t e0, e1;
        e0 = expectAt(M0, S0, L0, t0);
        e1 = expectAt(M1, S1, L1, t1);
        if (e0.valid != 0) begin held0x = e0.cx; held0y = e0.cy; end
        else begin e0.cx = held0x; e0.cy = held0y; end
        if (e1.valid != 0) begin held1x = e1.cx; held1y = e1.cy; end
        else begin e1.cx = held1x; e1.cy = held1y; end
        checkDut("dflt", e0, d0_busy, d0_done, d0_curEn, d0_curAddr, d0_sprEn, d0_row, d0_col,
                 d0_enCpr, d0_enSpr, d0_valid, d0_cx, d0_cy);
        checkDut("small", e1, d1_busy, d1_done, d1_curEn, d1_curAddr, d1_sprEn, d1_row, d1_col,
                 d1_enCpr, d1_enSpr, d1_valid, d1_cx, d1_cy);
        if (t0 == 1) validCnt0 = 0;
        if (t1 == 1) validCnt1 = 0;
        validCnt0 += int'(d0_valid);
        validCnt1 += int'(d1_valid);
        if (t0 == TOTAL0 + 1) checkOutput("dflt.validCount", validCnt0, NX0 * NX0);
        if (t1 == TOTAL1 + 1) checkOutput("small.validCount", validCnt1, NX1 * NX1);
    endtask

    task automatic applyStimulus(input logic st0, input logic st1);
        @(negedge clk);
        start0 = st0;
        start1 = st1;
        @(posedge clk);
        if (rst) begin
            t0 = 0;
            t1 = 0;
        end else begin
            t0 = advance(t0, st0, TOTAL0);
            t1 = advance(t1, st1, TOTAL1);
        end
        #1;
        evaluateAll();
    endtask

    // Mid-run reset: outputs must clear before any clock edge, then stay quiet until a new start.
    task automatic applyReset();
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        rst = 1'b1;
        #1;
        t0 = 0; t1 = 0;
        held0x = 0; held0y = 0; held1x = 0; held1y = 0;
        evaluateAll();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    function automatic logic pickStart(int t, int total);
        if (t == 0) return ($urandom_range(0, 3) == 0);
        if (t == total + 1) return 1'b1;
        return ($urandom_range(0, 39) == 0);
    endfunction

    initial begin
        int rstAt;
        rstAt = 3500 + int'($urandom_range(0, 400));
        $display("[TB] starting, mid-run reset at loop cycle %0d", rstAt);
        applyReset();
        applyStimulus(1'b1, 1'b1);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc == rstAt) applyReset();
            else applyStimulus(pickStart(t0, TOTAL0), pickStart(t1, TOTAL1));
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
